// File: rtl/alu_issuer.sv
// Issues one command at a time to a fixed-latency registered ALU and returns the tagged result.
// Also keeps a wrapping count of completed operations and a saturating count of overflowing ones.
module alu_issuer #(
  parameter int NUMBITS = 32,
  parameter int LATENCY = 1,
  parameter int TAGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [NUMBITS-1:0] cmd_a,
  input  logic [NUMBITS-1:0] cmd_b,
  input  logic [2:0]         cmd_opcode,
  input  logic [TAGBITS-1:0] cmd_tag,
  output logic [NUMBITS-1:0] alu_a,
  output logic [NUMBITS-1:0] alu_b,
  output logic [2:0]         alu_opcode,
  input  logic [NUMBITS-1:0] alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [NUMBITS-1:0] rsp_result,
  output logic               rsp_carryout,
  output logic               rsp_overflow,
  output logic               rsp_zero,
  output logic [TAGBITS-1:0] rsp_tag,
  input  logic               stats_clr,
  output logic [15:0]        op_count,
  output logic [15:0]        ovf_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Counter must hold LATENCY itself; a zero-latency build still needs one bit.
  localparam int CNTW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  state_t              state_reg, state_next;
  logic [CNTW-1:0]     wait_cnt_reg;
  logic [TAGBITS-1:0]  tag_reg;
  logic                accept;
  logic                capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = WAIT;
      end
      WAIT: begin
        if (wait_cnt_reg == '0) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        cmd_ready = rsp_ready;
        if (rsp_ready) state_next = cmd_valid ? WAIT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept  = cmd_valid && cmd_ready;
  assign capture = (state_reg == WAIT) && (wait_cnt_reg == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
      tag_reg      <= '0;
      wait_cnt_reg <= '0;
    end else if (accept) begin
      alu_a        <= cmd_a;
      alu_b        <= cmd_b;
      alu_opcode   <= cmd_opcode;
      tag_reg      <= cmd_tag;
      wait_cnt_reg <= CNTW'(LATENCY);
    end else if (state_reg == WAIT && wait_cnt_reg != '0) begin
      wait_cnt_reg <= wait_cnt_reg - 1'b1;
    end
  end

  // Response registers only load on capture, so they hold while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result   <= '0;
      rsp_carryout <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_tag      <= '0;
    end else if (capture) begin
      rsp_result   <= alu_result;
      rsp_carryout <= alu_carryout;
      rsp_overflow <= alu_overflow;
      rsp_zero     <= alu_zero;
      rsp_tag      <= tag_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (stats_clr) begin
      op_count  <= '0;
      ovf_count <= '0;
    end else if (capture) begin
      op_count <= op_count + 16'd1;
      if (alu_overflow && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
    end
  end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 The block SHALL have parameter NUMBITS, default 32, giving the operand/result width.
REQ-002 The block SHALL have parameter LATENCY, default 1, giving the ALU cycles from operand drive to registered result.
REQ-003 The block SHALL have parameter TAGBITS, default 4, giving the command tag width.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  command accepted on edge where valid and ready are both high.
REQ-008 cmd_a, cmd_b  input  NUMBITS each  operands.
REQ-009 cmd_opcode  input  3  ALU opcode (0 add, 1 signed add, 2 sub, 3 signed sub, 4 and, 5 or, 6 xor, 7 shift-left-1).
REQ-010 cmd_tag  input  TAGBITS  caller tag, returned with the response.
REQ-011 alu_a, alu_b  output  NUMBITS each  registered operands to the ALU.
REQ-012 alu_opcode  output  3  registered opcode to the ALU.
REQ-013 alu_result  input  NUMBITS; alu_carryout, alu_overflow, alu_zero  input  1 each  ALU registered outputs.
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_result  output  NUMBITS; rsp_carryout, rsp_overflow, rsp_zero  output  1 each; rsp_tag  output  TAGBITS  captured response.
REQ-017 stats_clr  input  1  synchronous clear of both counters.
REQ-018 op_count  output  16  completed operations, wrapping.
REQ-019 ovf_count  output  16  completed operations with overflow, saturating.

Function
REQ-020 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-021 cmd_ready SHALL be high in IDLE, and in RESP when rsp_ready is high; low otherwise.
REQ-022 On accept, alu_a/alu_b/alu_opcode and an internal tag register SHALL load from cmd_*; a wait counter SHALL load LATENCY; state SHALL go to WAIT.
REQ-023 alu_a/alu_b/alu_opcode SHALL change only on an accept edge and hold otherwise.
REQ-024 In WAIT, the counter SHALL decrement each edge while nonzero; on the edge where it is zero, the block SHALL capture alu_* into rsp_* (tag from the tag register) and go to RESP.
REQ-025 Latency SHALL be fixed: with accept at edge k, rsp_valid SHALL rise after edge k+LATENCY+1 (k+2 at default).
REQ-026 rsp_valid SHALL be high exactly in RESP; rsp_* SHALL hold stable while rsp_valid is high and rsp_ready is low.
REQ-027 In RESP with rsp_ready high: if cmd_valid is high, the new command SHALL be accepted on the same edge (state to WAIT); otherwise state SHALL go to IDLE.
REQ-028 At most one command SHALL be outstanding; cmd_valid in WAIT SHALL be ignored.
REQ-029 On each capture edge, op_count SHALL increment modulo 2^16, and ovf_count SHALL increment if alu_overflow is high, holding at 16'hFFFF.
REQ-030 stats_clr high SHALL zero both counters on that edge, taking priority over a simultaneous increment.

Reset
REQ-031 Assertion of reset SHALL asynchronously force state IDLE, counter 0, and all outputs 0 except cmd_ready, which SHALL be 1 while in IDLE.
REQ-032 Reset in WAIT or RESP SHALL discard the pending command; no response for it SHALL ever appear.
REQ-033 After reset deassertion, the first rising edge with cmd_valid high SHALL accept a command.

Verification (bench instantiates the 32-bit ALU, LATENCY=1)
REQ-034 opcode 0, A=FFFFFFFF, B=1, tag 3, accepted at edge k -> rsp_valid after edge k+2; result 0, carryout 1, zero 1, tag 3; op_count 1.
REQ-035 opcode 1, A=7FFFFFFF, B=1 -> result 80000000, overflow 1, zero 0; ovf_count increments by 1.
REQ-036 rsp_ready held low 5 cycles in RESP -> rsp_* stable, cmd_ready 0. rsp_ready and cmd_valid then both high (opcode 6, A=F0F0F0F0, B=FFFFFFFF) -> same-edge accept, next result 0F0F0F0F.
REQ-037 reset pulsed mid-WAIT without clock edge -> rsp_valid 0 and alu_* 0 immediately; no stale response after release.
REQ-038 stats_clr high on a capture edge with overflow -> ovf_count and op_count 0 after that edge.
REQ-039 65536 overflowing operations -> ovf_count stays 16'hFFFF; op_count wraps to 0.
